// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel edge-magnitude stage.
package sobel_pkg;

  localparam int IMG_W_DEF  = 128;
  localparam int IMG_H_DEF  = 128;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_PIX    = (1 << DATA_W_DEF) - 1;
  localparam int COL_W_DEF  = $clog2(IMG_W_DEF);
  localparam int ROW_W_DEF  = $clog2(IMG_H_DEF);
  localparam int GRAD_W_DEF = DATA_W_DEF + 3;

  // Signed gradient width: max |G| = 4*(2^DATA_W-1) needs two extra magnitude bits plus sign.
  function automatic int gradWidth(input int dataW);
    return dataW + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of storage: asynchronous read, synchronous write, no reset on contents.
module sobel_line_buffer #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] memQ [DEPTH];

  assign rdata_o = memQ[addr_i];

  always_ff @(posedge Clk) begin
    if (we_i) memQ[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel |Gx|+|Gy| stage with two line buffers and a 2-cycle output pipeline.
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              Valid_in,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              Last_in,
  output logic              Valid_out,
  output logic [DATA_W-1:0] Data_out,
  output logic              Last_out,
  output logic              Frame_err
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int GRAD_W = gradWidth(DATA_W);
  localparam int MAG_W  = DATA_W + 4;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [MAG_W-1:0] MAG_CLIP = MAG_W'((1 << DATA_W) - 1);

  logic [COL_W-1:0]  colQ, colD;
  logic [ROW_W-1:0]  rowQ, rowD;
  logic              atEnd, interior, acceptQual;
  logic [DATA_W-1:0] lb1Rd, lb2Rd;
  logic [DATA_W-1:0] winQ [3][3];
  logic signed [GRAD_W-1:0] sx [3][3];
  logic signed [GRAD_W-1:0] gxD, gyD, gxQ, gyQ;
  logic [GRAD_W-1:0] absX, absY;
  logic [MAG_W-1:0]  magD;
  logic [DATA_W-1:0] dataOutD, dataOutQ;
  logic              v0Q, last0Q, v1Q, last1Q;
  logic              validOutQ, lastOutQ, frameErrQ;

  assign atEnd      = (colQ == COL_LAST) && (rowQ == ROW_LAST);
  assign interior   = (colQ >= COL_TWO) && (rowQ >= ROW_TWO);
  assign acceptQual = Valid_in && !rst;

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) lb1 (
    .Clk     (Clk),
    .we_i    (acceptQual),
    .addr_i  (colQ),
    .wdata_i (Data_in),
    .rdata_o (lb1Rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) lb2 (
    .Clk     (Clk),
    .we_i    (acceptQual),
    .addr_i  (colQ),
    .wdata_i (lb1Rd),
    .rdata_o (lb2Rd)
  );

  // An early Last_in resynchronises the position to (0,0) after the beat is processed.
  always_comb begin
    colD = colQ;
    rowD = rowQ;
    if (Valid_in) begin
      if (Last_in && !atEnd) begin
        colD = '0;
        rowD = '0;
      end else if (colQ == COL_LAST) begin
        colD = '0;
        rowD = (rowQ == ROW_LAST) ? '0 : rowQ + 1'b1;
      end else begin
        colD = colQ + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      colQ      <= '0;
      rowQ      <= '0;
      v0Q       <= 1'b0;
      last0Q    <= 1'b0;
      frameErrQ <= 1'b0;
    end else begin
      colQ      <= colD;
      rowQ      <= rowD;
      v0Q       <= Valid_in && interior;
      last0Q    <= Valid_in && atEnd;
      frameErrQ <= Valid_in && (Last_in != atEnd);
    end
  end

  // Window column 2 is the newest; rows are top (oldest line) to bottom (current line).
  always_ff @(posedge Clk) begin
    if (acceptQual) begin
      for (int r = 0; r < 3; r++) begin
        winQ[r][0] <= winQ[r][1];
        winQ[r][1] <= winQ[r][2];
      end
      winQ[0][2] <= lb2Rd;
      winQ[1][2] <= lb1Rd;
      winQ[2][2] <= Data_in;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        sx[r][k] = signed'(GRAD_W'(winQ[r][k]));
      end
    end
    gxD = (sx[0][2] + (sx[1][2] <<< 1) + sx[2][2]) - (sx[0][0] + (sx[1][0] <<< 1) + sx[2][0]);
    gyD = (sx[2][0] + (sx[2][1] <<< 1) + sx[2][2]) - (sx[0][0] + (sx[0][1] <<< 1) + sx[0][2]);
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      v1Q    <= 1'b0;
      last1Q <= 1'b0;
      gxQ    <= '0;
      gyQ    <= '0;
    end else begin
      v1Q    <= v0Q;
      last1Q <= last0Q;
      gxQ    <= gxD;
      gyQ    <= gyD;
    end
  end

  always_comb begin
    absX     = gxQ[GRAD_W-1] ? GRAD_W'(-gxQ) : GRAD_W'(gxQ);
    absY     = gyQ[GRAD_W-1] ? GRAD_W'(-gyQ) : GRAD_W'(gyQ);
    magD     = MAG_W'(absX) + MAG_W'(absY);
    dataOutD = (magD > MAG_CLIP) ? MAG_CLIP[DATA_W-1:0] : magD[DATA_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      validOutQ <= 1'b0;
      dataOutQ  <= '0;
      lastOutQ  <= 1'b0;
    end else begin
      validOutQ <= v1Q;
      lastOutQ  <= last1Q;
      if (v1Q) dataOutQ <= dataOutD;
    end
  end

  assign Valid_out = validOutQ;
  assign Data_out  = dataOutQ;
  assign Last_out  = lastOutQ;
  assign Frame_err = frameErrQ;

endmodule

// File: tb/tb_sobel_filter.sv
// Directed bench for sobel_filter on a reduced 32x16 frame with hand-derived edge magnitudes.
module tb_sobel_filter;

  localparam int W    = 32;
  localparam int H    = 16;
  localparam int DW   = 8;
  localparam int NOUT = (W - 2) * (H - 2);

  logic          Clk = 1'b0;
  logic          rst;
  logic          Valid_in;
  logic [DW-1:0] Data_in;
  logic          Last_in;
  logic          Valid_out;
  logic [DW-1:0] Data_out;
  logic          Last_out;
  logic          Frame_err;

  sobel_filter #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .Clk       (Clk),
    .rst       (rst),
    .Valid_in  (Valid_in),
    .Data_in   (Data_in),
    .Last_in   (Last_in),
    .Valid_out (Valid_out),
    .Data_out  (Data_out),
    .Last_out  (Last_out),
    .Frame_err (Frame_err)
  );

  always #5 Clk = ~Clk;

  int edgeCnt = 0;
  always @(posedge Clk) edgeCnt <= edgeCnt + 1;

  int nChecks = 0;
  int nFails  = 0;

  int          obsEdge[$];
  logic [7:0]  obsData[$];
  logic        obsLast[$];
  int          errEdge[$];
  int          expEdge[$];
  int          expCol[$];
  logic        expLast[$];
  int          expErr[$];
  int          mRow = 0;
  int          mCol = 0;

  // Output monitor: record every observed pulse with the edge index that produced it.
  always @(negedge Clk) begin
    if (Valid_out === 1'b1) begin
      obsEdge.push_back(edgeCnt);
      obsData.push_back(Data_out);
      obsLast.push_back(Last_out);
    end
    if (Frame_err === 1'b1) errEdge.push_back(edgeCnt);
  end

  task automatic clearLogs();
    obsEdge.delete(); obsData.delete(); obsLast.delete(); errEdge.delete();
    expEdge.delete(); expCol.delete(); expLast.delete(); expErr.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  // One accepted beat; the bench tracks raster position independently to know which beats output.
  task automatic sendBeat(input logic [7:0] d, input logic l);
    int  id;
    logic atEnd;
    Valid_in = 1'b1; Data_in = d; Last_in = l;
    @(posedge Clk); #1;
    id    = edgeCnt;
    atEnd = (mRow == H - 1) && (mCol == W - 1);
    if (mRow >= 2 && mCol >= 2) begin
      expEdge.push_back(id);
      expCol.push_back(mCol - 1);
      expLast.push_back(atEnd);
    end
    if (l != atEnd) expErr.push_back(id);
    if (l && !atEnd) begin
      mRow = 0; mCol = 0;
    end else if (mCol == W - 1) begin
      mCol = 0;
      mRow = atEnd ? 0 : mRow + 1;
    end else begin
      mCol = mCol + 1;
    end
    Valid_in = 1'b0; Data_in = '0; Last_in = 1'b0;
  endtask

  function automatic logic [7:0] pixelOf(input int kind, input int c);
    if (kind == 0) return 8'd100;
    if (kind == 1) return (c < W / 2) ? 8'd0 : 8'd255;
    return 8'(c);
  endfunction

  task automatic sendFrame(input int kind, input bit gaps, input bit withLast);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        sendBeat(pixelOf(kind, c), withLast && (r == H - 1) && (c == W - 1));
        if (gaps && c == W - 1) idle(2);
      end
    end
    idle(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; Valid_in = 1'b0; Data_in = '0; Last_in = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    nChecks++; if (Valid_out !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b expected 0", Valid_out); end
    nChecks++; if (Data_out !== 8'd0) begin nFails++; $display("[TB] FAIL reset_data: got %0d expected 0", Data_out); end
    nChecks++; if (Last_out !== 1'b0) begin nFails++; $display("[TB] FAIL reset_last: got %b expected 0", Last_out); end
    nChecks++; if (Frame_err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_err: got %b expected 0", Frame_err); end
    rst = 1'b0;
    @(posedge Clk); #1;
    mRow = 0; mCol = 0;
  endtask

  task automatic test_constant_frame();
    clearLogs();
    sendFrame(0, 1'b0, 1'b1);
    nChecks++; if (obsData.size() != NOUT) begin nFails++; $display("[TB] FAIL const_count: got %0d expected %0d", obsData.size(), NOUT); end
    foreach (obsData[i]) begin
      nChecks++; if (obsData[i] !== 8'd0) begin nFails++; $display("[TB] FAIL const_data[%0d]: got %0d expected 0", i, obsData[i]); end
      nChecks++; if (obsLast[i] !== (i == NOUT - 1)) begin nFails++; $display("[TB] FAIL const_last[%0d]: got %b expected %b", i, obsLast[i], i == NOUT - 1); end
    end
    nChecks++; if (errEdge.size() != 0) begin nFails++; $display("[TB] FAIL const_err: got %0d pulses expected 0", errEdge.size()); end
  endtask

  task automatic test_vertical_edge();
    int hits = 0;
    logic [7:0] want;
    clearLogs();
    sendFrame(1, 1'b0, 1'b1);
    nChecks++; if (obsData.size() != NOUT) begin nFails++; $display("[TB] FAIL edge_count: got %0d expected %0d", obsData.size(), NOUT); end
    for (int i = 0; i < obsData.size() && i < expCol.size(); i++) begin
      want = (expCol[i] == W / 2 - 1 || expCol[i] == W / 2) ? 8'd255 : 8'd0;
      if (want == 8'd255) hits++;
      nChecks++; if (obsData[i] !== want) begin nFails++; $display("[TB] FAIL edge_data[%0d] col %0d: got %0d expected %0d", i, expCol[i], obsData[i], want); end
    end
    nChecks++; if (hits != 2 * (H - 2)) begin nFails++; $display("[TB] FAIL edge_hits: got %0d expected %0d", hits, 2 * (H - 2)); end
  endtask

  task automatic test_ramp();
    clearLogs();
    sendFrame(2, 1'b0, 1'b1);
    nChecks++; if (obsData.size() != NOUT) begin nFails++; $display("[TB] FAIL ramp_count: got %0d expected %0d", obsData.size(), NOUT); end
    for (int i = 0; i < obsData.size() && i < expEdge.size(); i++) begin
      nChecks++; if (obsData[i] !== 8'd8) begin nFails++; $display("[TB] FAIL ramp_data[%0d]: got %0d expected 8", i, obsData[i]); end
      nChecks++; if (obsEdge[i] != expEdge[i] + 2) begin nFails++; $display("[TB] FAIL ramp_latency[%0d]: got edge %0d expected %0d", i, obsEdge[i], expEdge[i] + 2); end
    end
  endtask

  task automatic test_gaps();
    clearLogs();
    sendFrame(2, 1'b1, 1'b1);
    nChecks++; if (obsData.size() != NOUT) begin nFails++; $display("[TB] FAIL gaps_count: got %0d expected %0d", obsData.size(), NOUT); end
    for (int i = 0; i < obsData.size() && i < expEdge.size(); i++) begin
      nChecks++; if (obsData[i] !== 8'd8) begin nFails++; $display("[TB] FAIL gaps_data[%0d]: got %0d expected 8", i, obsData[i]); end
      nChecks++; if (obsEdge[i] != expEdge[i] + 2) begin nFails++; $display("[TB] FAIL gaps_latency[%0d]: got edge %0d expected %0d", i, obsEdge[i], expEdge[i] + 2); end
      nChecks++; if (obsLast[i] !== expLast[i]) begin nFails++; $display("[TB] FAIL gaps_last[%0d]: got %b expected %b", i, obsLast[i], expLast[i]); end
    end
    nChecks++; if (errEdge.size() != 0) begin nFails++; $display("[TB] FAIL gaps_err: got %0d pulses expected 0", errEdge.size()); end
  endtask

  task automatic test_frame_error();
    clearLogs();
    for (int i = 0; i <= 100; i++) sendBeat(pixelOf(2, i % W), i == 100);
    idle(4);
    nChecks++; if (errEdge.size() != 1) begin nFails++; $display("[TB] FAIL early_last_pulses: got %0d expected 1", errEdge.size()); end
    if (errEdge.size() > 0 && expErr.size() > 0) begin
      nChecks++; if (errEdge[0] != expErr[0]) begin nFails++; $display("[TB] FAIL early_last_edge: got %0d expected %0d", errEdge[0], expErr[0]); end
    end
    clearLogs();
    sendFrame(2, 1'b0, 1'b1);
    nChecks++; if (obsData.size() != NOUT) begin nFails++; $display("[TB] FAIL resync_count: got %0d expected %0d", obsData.size(), NOUT); end
    foreach (obsData[i]) begin
      nChecks++; if (obsData[i] !== 8'd8) begin nFails++; $display("[TB] FAIL resync_data[%0d]: got %0d expected 8", i, obsData[i]); end
      nChecks++; if (obsLast[i] !== (i == NOUT - 1)) begin nFails++; $display("[TB] FAIL resync_last[%0d]: got %b expected %b", i, obsLast[i], i == NOUT - 1); end
    end
    nChecks++; if (errEdge.size() != 0) begin nFails++; $display("[TB] FAIL resync_err: got %0d pulses expected 0", errEdge.size()); end
    clearLogs();
    sendFrame(0, 1'b0, 1'b0);
    nChecks++; if (errEdge.size() != 1) begin nFails++; $display("[TB] FAIL missing_last_pulses: got %0d expected 1", errEdge.size()); end
    if (errEdge.size() > 0 && expErr.size() > 0) begin
      nChecks++; if (errEdge[0] != expErr[0]) begin nFails++; $display("[TB] FAIL missing_last_edge: got %0d expected %0d", errEdge[0], expErr[0]); end
    end
  endtask

  task automatic test_mid_frame_reset();
    int resetEdge;
    int late = 0;
    clearLogs();
    for (int i = 0; i < 300; i++) sendBeat(8'd100, 1'b0);
    rst = 1'b1; Valid_in = 1'b1; Data_in = 8'd100;
    @(posedge Clk); #1;
    resetEdge = edgeCnt;
    rst = 1'b0; Valid_in = 1'b0; Data_in = '0;
    mRow = 0; mCol = 0;
    idle(4);
    foreach (obsEdge[i]) if (obsEdge[i] >= resetEdge) late++;
    nChecks++; if (late != 0) begin nFails++; $display("[TB] FAIL reset_flush: got %0d outputs after reset expected 0", late); end
    clearLogs();
    sendFrame(0, 1'b0, 1'b1);
    nChecks++; if (obsData.size() != NOUT) begin nFails++; $display("[TB] FAIL post_reset_count: got %0d expected %0d", obsData.size(), NOUT); end
    for (int i = 0; i < obsData.size() && i < expEdge.size(); i++) begin
      nChecks++; if (obsData[i] !== 8'd0) begin nFails++; $display("[TB] FAIL post_reset_data[%0d]: got %0d expected 0", i, obsData[i]); end
      nChecks++; if (obsLast[i] !== (i == NOUT - 1)) begin nFails++; $display("[TB] FAIL post_reset_last[%0d]: got %b expected %b", i, obsLast[i], i == NOUT - 1); end
      nChecks++; if (obsEdge[i] != expEdge[i] + 2) begin nFails++; $display("[TB] FAIL post_reset_latency[%0d]: got edge %0d expected %0d", i, obsEdge[i], expEdge[i] + 2); end
    end
  endtask

  initial begin
    rst = 1'b1; Valid_in = 1'b0; Data_in = '0; Last_in = 1'b0;
    test_reset();
    test_constant_frame();
    test_vertical_edge();
    test_ramp();
    test_gaps();
    test_frame_error();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sobel_filter.md
# sobel_filter

Streaming 3×3 Sobel edge-magnitude stage for the sobel image pipeline. It consumes the 8-bit pixel stream from the input streaming stage (Valid/Data/Last, no backpressure) and buffers two image lines. Per accepted pixel it forms a 3×3 window and computes the clipped gradient magnitude |Gx|+|Gy|. It emits one output pixel per interior input position, with Last marking the final interior pixel of the frame.

## Interface
- IMG_W, 128, pixels per line (≥3)
- IMG_H, 128, lines per frame (≥3)
- DATA_W, 8, pixel width
- Clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- Valid_in  in  1  Data_in/Last_in valid this cycle; no ready, every valid beat is accepted
- Data_in  in  DATA_W  input pixel, raster order
- Last_in  in  1  final pixel of frame, qualified by Valid_in
- Valid_out  out  1  Data_out valid, single-cycle pulse per output pixel
- Data_out  out  DATA_W  edge magnitude, saturated to 2^DATA_W−1
- Last_out  out  1  with Valid_out on the last interior pixel of the frame
- Frame_err  out  1  one-cycle pulse on Last_in/position mismatch

## Operation
- Counters col (0..IMG_W−1) and row (0..IMG_H−1) advance on each accepted beat. col wraps to 0 and increments row; at (IMG_H−1, IMG_W−1) both wrap to 0.
- Two line buffers, IMG_W × DATA_W each, asynchronous read:
  - On accept at col c, read lb1[c] (row−1) and lb2[c] (row−2) first.
  - Then write lb1[c]←Data_in and lb2[c]←old lb1[c].
  - Contents are not reset.
- Window p[r][k], r,k∈0..2, row 0 = top, column 2 = newest. It shifts left only on accept; the new column is {lb2[c], lb1[c], Data_in}.
- After accepting (row, col), the window centre is pixel (row−1, col−1). It is interior and produces output iff row≥2 and col≥2, giving (IMG_H−2)×(IMG_W−2) = 15876 outputs per frame at defaults. Border pixels produce no output.
- Gx = (p02+2p12+p22) − (p00+2p10+p20). Gy = (p20+2p21+p22) − (p00+2p01+p02).
  - Gx and Gy are signed, DATA_W+3 bits.
  - mag = |Gx|+|Gy| in DATA_W+4 bits (max 2040).
  - Data_out = min(mag, 255).
- Last_out: asserted with the output produced by the input at (IMG_H−1, IMG_W−1).
- Frame check:
  - Valid_in & Last_in at any position other than (IMG_H−1, IMG_W−1): Frame_err pulses, that beat is processed normally, then col/row are forced to 0 (resync).
  - Valid_in at (IMG_H−1, IMG_W−1) with Last_in=0: Frame_err pulses; normal wrap.
- Gaps in Valid_in are allowed anywhere, including across line and frame boundaries. Output values are independent of gap pattern.

## Timing
- Pipeline:
  - E0 = edge sampling the accepted input: window and counters update.
  - E0+1: Gx/Gy and stage valid/last registered.
  - E0+2: Valid_out, Data_out, Last_out registered.
  - Fixed latency of 2 cycles; the pipeline never stalls.
- Back-to-back accepts give back-to-back outputs (1 pixel/clock throughput).
- Frame_err is registered at E0 for the offending beat.
- Reset values: Valid_out=0, Data_out=0, Last_out=0, Frame_err=0, col=row=0, all stage valid bits=0.
- Reset mid-frame: in-flight results are discarded; no Valid_out after the reset edge. The next accepted beat is treated as (0,0).
- Reset and Valid_in together: reset wins and the beat is dropped.

## Structure
- Shared package sobel_pkg holds:
  - default IMG_W/IMG_H/DATA_W constants
  - MAX_PIX = 2^DATA_W−1
  - counter widths via $clog2(IMG_W) and $clog2(IMG_H)
  - the signed gradient width constant
- One sub-module, sobel_line_buffer: parameterised depth/width RAM with async read and sync write. It is instantiated twice (lb1, lb2).
- Counters, window, gradient pipeline and frame check live in sobel_filter.

## Test plan
- Constant frame, all pixels 100, continuous valid -> exactly 15876 Valid_out pulses, all Data_out=0. Last_out only on the 15876th pulse; Frame_err never.
- Vertical edge (cols 0..63=0, cols 64..127=255) -> Data_out=255 at output cols 63 and 64 (Gx=1020 clipped), 0 elsewhere, on all 126 interior rows.
- Horizontal ramp, pixel = col -> every output = 8 (Gx=8, Gy=0).
- Ramp frame with Valid_in at random 50% duty and idle gaps spanning line ends -> output sequence identical to continuous case. Each Valid_out exactly 2 cycles after the accepting edge of input (r+1, c+1).
- Last_in asserted on pixel index 100 -> Frame_err single pulse on that beat. The following correct frame yields 15876 correct outputs with Last_out on the final one.
- Assert rst for 1 cycle after 5000 pixels -> Valid_out low from the next edge. The subsequent full constant-100 frame gives 15876 zero outputs with correct Last_out.
